// File: rtl/fifo_sync_flagged.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read port and sticky overflow/underflow flags.
module fifo_sync_flagged #(
  parameter int FIFO_data_size = 8,
  parameter int FIFO_addr_size = 4,
  parameter int AFULL_TH       = 12,
  parameter int AEMPTY_TH      = 4,
  parameter int FWFT           = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [FIFO_data_size-1:0] data_in,
  input  logic                      r_en,
  output logic [FIFO_data_size-1:0] data_out,
  output logic                      data_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [FIFO_addr_size:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int DEPTH = 1 << FIFO_addr_size;
  localparam logic [FIFO_addr_size:0] C_DEPTH  = DEPTH[FIFO_addr_size:0];
  localparam logic [FIFO_addr_size:0] C_AFULL  = AFULL_TH[FIFO_addr_size:0];
  localparam logic [FIFO_addr_size:0] C_AEMPTY = AEMPTY_TH[FIFO_addr_size:0];

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_sync_flagged: AFULL_TH must be within 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_flagged: AEMPTY_TH must be within 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_sync_flagged: FWFT must be 0 or 1");
  end

  logic [FIFO_data_size-1:0] r_mem [DEPTH];
  logic [FIFO_addr_size-1:0] r_w_ptr;
  logic [FIFO_addr_size-1:0] r_r_ptr;
  logic [FIFO_addr_size:0]   r_count;
  logic                      r_overflow;
  logic                      r_underflow;
  logic                      w_wr_acc;
  logic                      w_rd_acc;

  // Handshake: a write is accepted when w_en && !full, a read when r_en && !empty,
  // both judged on the registered state at the clock edge. A rejected request has
  // no effect other than setting its sticky error flag.
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = w_en && !full;
  assign w_rd_acc = r_en && !empty;

  // Storage has no reset; the reset cycle must still not write.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[r_w_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) begin
        r_w_ptr <= r_w_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_r_ptr <= r_r_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  && !clr_err) || (w_en && full);
      r_underflow <= (r_underflow && !clr_err) || (r_en && empty);
    end
  end

  if (FWFT == 0) begin : g_std
    logic [FIFO_data_size-1:0] r_data_out;
    logic                      r_data_valid;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_data_out   <= '0;
        r_data_valid <= 1'b0;
      end else begin
        r_data_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_data_out <= r_mem[r_r_ptr];
        end
      end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
  end else begin : g_fwft
    // Head of queue is always presented; r_en acts as the pop acknowledge.
    assign data_out   = r_mem[r_r_ptr];
    assign data_valid = !empty;
  end

endmodule

// File: tb/tb_fifo_sync_flagged.sv
// Bench for fifo_sync_flagged: standard and FWFT instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_fifo_sync_flagged;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFTH  = 12;
  localparam int AETH  = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     = 1'b0;
  logic          w_en    = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          r_en    = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] s_do, f_do;
  logic          s_dv, f_dv, s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
  logic [AW:0]   s_cnt, f_cnt;

  fifo_sync_flagged #(.FIFO_data_size(DW), .FIFO_addr_size(AW), .AFULL_TH(AFTH),
                      .AEMPTY_TH(AETH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(s_do), .data_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
  );

  fifo_sync_flagged #(.FIFO_data_size(DW), .FIFO_addr_size(AW), .AFULL_TH(AFTH),
                      .AEMPTY_TH(AETH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_do), .data_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  // scoreboard: expected queue plus flag / read-port model
  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_udf, m_sdv;
  logic [DW-1:0] m_sdo;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string p, input logic [AW:0] cnt, input logic emp,
                           input logic ful, input logic af, input logic ae,
                           input logic ov, input logic un);
    int n;
    n = exp_q.size();
    check({p, "_count"}, 32'(cnt), 32'(n));
    check({p, "_empty"}, 32'(emp), 32'(n == 0));
    check({p, "_full"},  32'(ful), 32'(n == DEPTH));
    check({p, "_afull"}, 32'(af),  32'(n >= AFTH));
    check({p, "_aempty"},32'(ae),  32'(n <= AETH));
    check({p, "_ovf"},   32'(ov),  32'(m_ovf));
    check({p, "_udf"},   32'(un),  32'(m_udf));
  endtask

  task automatic check_all();
    check_dut("std", s_cnt, s_empty, s_full, s_af, s_ae, s_ovf, s_udf);
    check_dut("fwft", f_cnt, f_empty, f_full, f_af, f_ae, f_ovf, f_udf);
    check("std_valid", 32'(s_dv), 32'(m_sdv));
    check("std_data", 32'(s_do), 32'(m_sdo));
    check("fwft_valid", 32'(f_dv), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("fwft_data", 32'(f_do), 32'(exp_q[0]));
  endtask

  // driver: one clock cycle of stimulus, model update, then compare on the falling edge
  task automatic cyc(input logic rn, input logic we, input logic [DW-1:0] d,
                     input logic re, input logic cl);
    bit is_full, is_empty, wa, ra;
    rst = rn; w_en = we; data_in = d; r_en = re; clr_err = cl;
    @(posedge clk);
    if (!rn) begin
      exp_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_sdv = 1'b0; m_sdo = '0;
    end else begin
      is_full  = (exp_q.size() == DEPTH);
      is_empty = (exp_q.size() == 0);
      wa = we && !is_full;
      ra = re && !is_empty;
      m_ovf = (m_ovf && !cl) || (we && is_full);
      m_udf = (m_udf && !cl) || (re && is_empty);
      m_sdv = ra;
      if (ra) m_sdo = exp_q.pop_front();
      if (wa) exp_q.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_ovf = 1'b0; m_udf = 1'b0; m_sdv = 1'b0; m_sdo = '0;
    @(negedge clk);

    // reset for two cycles, with requests that must be ignored
    cyc(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_aempty", 32'(s_ae), 32'd1);
    check("rst_count", 32'(s_cnt), 32'd0);

    // fill with 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_afull", 32'(s_af), 32'(i + 1 >= AFTH));
    end
    check("fill_full", 32'(s_full), 32'd1);
    check("fill_count", 32'(s_cnt), 32'd16);
    cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    check("ovf_set", 32'(s_ovf), 32'd1);
    check("ovf_count", 32'(s_cnt), 32'd16);

    // drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_valid", 32'(s_dv), 32'd1);
      check("drain_data", 32'(s_do), 32'(i));
    end
    check("drain_empty", 32'(s_empty), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", 32'(s_udf), 32'd1);
    check("udf_novalid", 32'(s_dv), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // preload 3, then simultaneous traffic across pointer wrap
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      check("wrap_count", 32'(s_cnt), 32'd3);
    end

    // FWFT single word
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_a5_valid", 32'(f_dv), 32'd1);
    check("fwft_a5_data", 32'(f_do), 32'hA5);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop_valid", 32'(f_dv), 32'd0);
    check("fwft_pop_empty", 32'(f_empty), 32'd1);

    // clr_err racing a new overflow, then alone
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h12, 1'b0, 1'b1);
    check("clr_race_ovf", 32'(s_ovf), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(s_ovf), 32'd0);

    // reset at count 9
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("pre_rst_count", 32'(s_cnt), 32'd9);
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    check("mid_rst_count", 32'(s_cnt), 32'd0);
    check("mid_rst_empty", 32'(f_empty), 32'd1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 99) < 55),
          8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
